// File: rtl/orion_vid_mem_arb.sv
// Video line fetcher and CPU port sharing one byte-wide RAM.
// Round-robin grant, three-stage access pipeline, line-buffer write-out.
module orion_vid_mem_arb #(
    parameter int          COLS       = 48,
    parameter logic [20:0] COL_STRIDE = 21'h00100,
    parameter logic [20:0] PLANE_OFS  = 21'h04000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [20:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_ack,
    input  logic        i_line_start,
    input  logic [20:0] i_line_addr,
    output logic        o_lb_we,
    output logic [6:0]  o_lb_addr,
    output logic [7:0]  o_lb_wdata,
    output logic        o_line_done,
    output logic        o_overrun,
    output logic [20:0] o_ram_addr,
    output logic        o_ram_we,
    output logic [7:0]  o_ram_wdata,
    input  logic [7:0]  i_ram_rdata
);

    typedef enum logic [1:0] {V_IDLE, V_FETCH, V_DRAIN} vstate_t;

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);

    vstate_t     vstate, vstate_nxt;
    logic [20:0] col_base;
    logic [5:0]  col;
    logic        plane;
    logic        last_cpu;

    logic        cpu_pend, vid_pend, grant_cpu, grant_vid;
    logic        fetch_last;
    logic [20:0] fetch_addr;

    logic        s1_valid, s1_cpu, s1_we, s1_last;
    logic [6:0]  s1_idx;
    logic        s2_valid, s2_cpu, s2_we, s2_last;
    logic [6:0]  s2_idx;

    // CPU is busy from grant until its ack cycle has passed
    assign cpu_pend = i_cpu_req && !(s1_valid && s1_cpu)
                    && !(s2_valid && s2_cpu) && !o_cpu_ack;
    assign vid_pend   = (vstate == V_FETCH);
    assign grant_cpu  = cpu_pend && (!vid_pend || !last_cpu);
    assign grant_vid  = vid_pend && !grant_cpu;
    assign fetch_last = (col == LAST_COL) && plane;
    assign fetch_addr = col_base + (plane ? PLANE_OFS : 21'h0);

    always_comb begin
        vstate_nxt = vstate;
        unique case (vstate)
            V_IDLE:  if (i_line_start) vstate_nxt = V_FETCH;
            V_FETCH: if (grant_vid && fetch_last) vstate_nxt = V_DRAIN;
            V_DRAIN: if (s2_valid && !s2_cpu && s2_last) vstate_nxt = V_IDLE;
            default: vstate_nxt = V_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vstate   <= V_IDLE;
            col_base <= '0;
            col      <= '0;
            plane    <= 1'b0;
            last_cpu <= 1'b0;
        end else begin
            vstate <= vstate_nxt;
            if (vstate == V_IDLE && i_line_start) begin
                col_base <= i_line_addr;
                col      <= '0;
                plane    <= 1'b0;
            end else if (grant_vid) begin
                plane <= !plane;
                if (plane) begin
                    col      <= col + 6'd1;
                    col_base <= col_base + COL_STRIDE;
                end
            end
            if (grant_cpu)
                last_cpu <= 1'b1;
            else if (grant_vid)
                last_cpu <= 1'b0;
        end
    end

    // E0: RAM address phase
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ram_addr  <= '0;
            o_ram_we    <= 1'b0;
            o_ram_wdata <= '0;
            s1_valid    <= 1'b0;
            s1_cpu      <= 1'b0;
            s1_we       <= 1'b0;
            s1_last     <= 1'b0;
            s1_idx      <= '0;
        end else begin
            if (grant_cpu)
                o_ram_addr <= i_cpu_addr;
            else if (grant_vid)
                o_ram_addr <= fetch_addr;
            o_ram_we <= grant_cpu && i_cpu_we;
            if (grant_cpu && i_cpu_we)
                o_ram_wdata <= i_cpu_wdata;
            s1_valid <= grant_cpu || grant_vid;
            s1_cpu   <= grant_cpu;
            s1_we    <= grant_cpu && i_cpu_we;
            s1_last  <= grant_vid && fetch_last;
            s1_idx   <= {col, plane};
        end
    end

    // E1: RAM data phase; E2: result registered
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_valid    <= 1'b0;
            s2_cpu      <= 1'b0;
            s2_we       <= 1'b0;
            s2_last     <= 1'b0;
            s2_idx      <= '0;
            o_cpu_ack   <= 1'b0;
            o_cpu_rdata <= '0;
            o_lb_we     <= 1'b0;
            o_lb_addr   <= '0;
            o_lb_wdata  <= '0;
            o_line_done <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_cpu   <= s1_cpu;
            s2_we    <= s1_we;
            s2_last  <= s1_last;
            s2_idx   <= s1_idx;

            o_cpu_ack <= s2_valid && s2_cpu;
            if (s2_valid && s2_cpu && !s2_we)
                o_cpu_rdata <= i_ram_rdata;
            o_lb_we <= s2_valid && !s2_cpu;
            if (s2_valid && !s2_cpu) begin
                o_lb_addr  <= s2_idx;
                o_lb_wdata <= i_ram_rdata;
            end
            o_line_done <= s2_valid && !s2_cpu && s2_last;
            o_overrun   <= i_line_start && (vstate != V_IDLE);
        end
    end

endmodule

// File: tb/tb_orion_vid_mem_arb.sv
// Scoreboard bench for orion_vid_mem_arb.
// Behavioural RAM plus queue-based expectations for CPU and video paths.
module tb_orion_vid_mem_arb;

    localparam int COLS   = 48;
    localparam int STRIDE = 256;
    localparam int OFS    = 16384;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cpu_req = 1'b0;
    logic        i_cpu_we = 1'b0;
    logic [20:0] i_cpu_addr = '0;
    logic [7:0]  i_cpu_wdata = '0;
    logic [7:0]  o_cpu_rdata;
    logic        o_cpu_ack;
    logic        i_line_start = 1'b0;
    logic [20:0] i_line_addr = '0;
    logic        o_lb_we;
    logic [6:0]  o_lb_addr;
    logic [7:0]  o_lb_wdata;
    logic        o_line_done;
    logic        o_overrun;
    logic [20:0] o_ram_addr;
    logic        o_ram_we;
    logic [7:0]  o_ram_wdata;
    logic [7:0]  i_ram_rdata = '0;

    orion_vid_mem_arb dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we),
        .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
        .o_cpu_rdata(o_cpu_rdata), .o_cpu_ack(o_cpu_ack),
        .i_line_start(i_line_start), .i_line_addr(i_line_addr),
        .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_wdata(o_lb_wdata),
        .o_line_done(o_line_done), .o_overrun(o_overrun),
        .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [20:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } cpu_exp_t;

    typedef struct {
        logic [6:0]  idx;
        logic [20:0] addr;
        logic [7:0]  data;
        logic        last;
    } vid_exp_t;

    cpu_exp_t cpu_q[$];
    vid_exp_t vid_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int first_cyc = 0;
    int span = 0;
    int exp_ovr = 0;
    int ram_we_cycles = 0;
    logic [7:0] last_rd = 8'h00;

    logic [7:0] mem [int];
    logic [7:0] ref_mem [int];
    logic [20:0] a1 = '0, a2 = '0;
    logic        we1 = 1'b0, we2 = 1'b0;
    logic [7:0]  d1 = '0, d2 = '0;

    function automatic logic [7:0] dflt(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [20:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic bad(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got unexpected event expected none", nm);
    endtask

    // RAM: read data valid the cycle after the address
    always @(posedge i_clk) begin
        cyc++;
        a1 <= o_ram_addr;
        a2 <= a1;
        we1 <= o_ram_we;
        we2 <= we1;
        d1 <= o_ram_wdata;
        d2 <= d1;
        if (mem.exists(int'(o_ram_addr)))
            i_ram_rdata <= mem[int'(o_ram_addr)];
        else
            i_ram_rdata <= dflt(o_ram_addr);
        if (o_ram_we) mem[int'(o_ram_addr)] = o_ram_wdata;
    end

    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_ram_we) ram_we_cycles++;
            if (o_cpu_ack) begin
                if (cpu_q.size() == 0) bad("cpu_ack_unexp");
                else begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    chk("cpu_ram_addr", 32'(a2), 32'(e.addr));
                    chk("cpu_ram_we", 32'(we2), 32'(e.we));
                    if (e.we) chk("cpu_ram_wdata", 32'(d2), 32'(e.wdata));
                    chk("cpu_rdata", 32'(o_cpu_rdata), 32'(e.rdata));
                end
            end
            if (o_lb_we) begin
                if (vid_q.size() == 0) bad("lb_we_unexp");
                else begin
                    vid_exp_t v;
                    v = vid_q.pop_front();
                    chk("lb_addr", 32'(o_lb_addr), 32'(v.idx));
                    chk("lb_fetch_addr", 32'(a2), 32'(v.addr));
                    chk("lb_ram_we", 32'(we2), 0);
                    chk("lb_wdata", 32'(o_lb_wdata), 32'(v.data));
                    chk("line_done", 32'(o_line_done), 32'(v.last));
                    if (v.idx == 0) first_cyc = cyc;
                    if (v.last) begin
                        span = cyc - first_cyc + 1;
                        done_cnt++;
                    end
                end
            end else if (o_line_done) begin
                bad("line_done_alone");
            end
            if (o_overrun) begin
                if (exp_ovr == 0) bad("overrun_unexp");
                else begin
                    exp_ovr--;
                    tests++;
                end
            end
        end
    end

    task automatic init_mem(input logic [20:0] a, input logic [7:0] d);
        mem[int'(a)] = d;
        ref_mem[int'(a)] = d;
    endtask

    task automatic pulse_start(input logic [20:0] a, input bit push);
        vid_exp_t v;
        @(negedge i_clk);
        i_line_start = 1'b1;
        i_line_addr  = a;
        if (push) begin
            for (int c = 0; c < COLS; c++) begin
                for (int p = 0; p < 2; p++) begin
                    v.idx  = 7'(c * 2 + p);
                    v.addr = 21'((int'(a) + c * STRIDE + p * OFS) % 2097152);
                    v.data = ref_rd(v.addr);
                    v.last = (c == COLS - 1) && (p == 1);
                    vid_q.push_back(v);
                end
            end
        end else begin
            exp_ovr++;
        end
        @(negedge i_clk);
        i_line_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 600) begin
            @(posedge i_clk);
            n++;
        end
        if (done_cnt < target) bad("line_done_timeout");
        repeat (2) @(posedge i_clk);
    endtask

    task automatic cpu_access(input logic we, input logic [20:0] a,
                              input logic [7:0] d, input int max_lat);
        cpu_exp_t e;
        int n;
        @(negedge i_clk);
        e.we = we;
        e.addr = a;
        e.wdata = d;
        if (we) begin
            ref_mem[int'(a)] = d;
            e.rdata = last_rd;
        end else begin
            e.rdata = ref_rd(a);
            last_rd = e.rdata;
        end
        cpu_q.push_back(e);
        i_cpu_req = 1'b1;
        i_cpu_we = we;
        i_cpu_addr = a;
        i_cpu_wdata = d;
        n = 0;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (!o_cpu_ack && n < 12);
        tests++;
        if (n > max_lat) begin
            fails++;
            $display("FAIL cpu_latency: got %0d edges expected <= %0d", n, max_lat);
        end
        i_cpu_req = 1'b0;
        @(posedge i_clk);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ack"}, 32'(o_cpu_ack), 0);
        chk({nm, "_lb_we"}, 32'(o_lb_we), 0);
        chk({nm, "_done"}, 32'(o_line_done), 0);
        chk({nm, "_ovr"}, 32'(o_overrun), 0);
        chk({nm, "_ram_we"}, 32'(o_ram_we), 0);
        chk({nm, "_ram_addr"}, 32'(o_ram_addr), 0);
        chk({nm, "_ram_wdata"}, 32'(o_ram_wdata), 0);
        chk({nm, "_rdata"}, 32'(o_cpu_rdata), 0);
        chk({nm, "_lb_addr"}, 32'(o_lb_addr), 0);
        chk({nm, "_lb_wdata"}, 32'(o_lb_wdata), 0);
    endtask

    initial begin
        int d0, w0;
        logic [20:0] la;

        repeat (3) @(posedge i_clk);
        #1;
        chk_reset_outs("rst");
        @(negedge i_clk);
        i_reset = 1'b0;

        init_mem(21'h01234, 8'hA5);
        cpu_access(1'b0, 21'h01234, 8'h00, 3);

        d0 = done_cnt;
        pulse_start(21'h0C000, 1'b1);
        wait_done(d0 + 1);
        chk("span_plain", 32'(span), 96);

        d0 = done_cnt;
        w0 = ram_we_cycles;
        pulse_start(21'h0C000, 1'b1);
        repeat (20) @(posedge i_clk);
        cpu_access(1'b1, 21'h00010, 8'h3C, 4);
        wait_done(d0 + 1);
        chk("span_cpu", 32'(span), 97);
        chk("ram_we_cycles", 32'(ram_we_cycles - w0), 1);
        cpu_access(1'b0, 21'h00010, 8'h00, 3);

        d0 = done_cnt;
        pulse_start(21'h0C000, 1'b1);
        repeat (10) @(posedge i_clk);
        pulse_start(21'h0E000, 1'b0);
        wait_done(d0 + 1);
        repeat (20) @(posedge i_clk);
        chk("ovr_done_cnt", 32'(done_cnt - d0), 1);
        chk("ovr_span", 32'(span), 96);
        chk("ovr_pending", 32'(exp_ovr), 0);

        d0 = done_cnt;
        pulse_start(21'h1FFF80, 1'b1);
        wait_done(d0 + 1);

        for (int k = 0; k < 6; k++) begin
            int nacc;
            la = 21'($urandom) & 21'h1FFF00;
            if ($urandom_range(1)) la = la | 21'h80;
            d0 = done_cnt;
            nacc = $urandom_range(4, 8);
            fork
                begin
                    pulse_start(la, 1'b1);
                    wait_done(d0 + 1);
                end
                begin
                    for (int j = 0; j < nacc; j++) begin
                        logic w;
                        logic [20:0] ca;
                        repeat ($urandom_range(1, 8)) @(posedge i_clk);
                        w = 1'($urandom_range(1));
                        ca = 21'($urandom);
                        if (w) ca = ca | 21'h1;
                        cpu_access(w, ca, 8'($urandom), 4);
                    end
                end
            join
        end

        for (int j = 0; j < 6; j++) begin
            logic w;
            logic [20:0] ca;
            w = 1'($urandom_range(1));
            ca = 21'($urandom) | 21'h1;
            cpu_access(w, ca, 8'($urandom), 3);
        end

        d0 = done_cnt;
        pulse_start(21'h02000, 1'b1);
        repeat (41) @(negedge i_clk);
        i_cpu_req = 1'b1;
        i_cpu_we = 1'b0;
        i_cpu_addr = 21'h00777;
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        chk_reset_outs("midrst");
        vid_q.delete();
        last_rd = 8'h00;
        @(negedge i_clk);
        #1;
        i_reset = 1'b0;
        i_cpu_req = 1'b0;
        repeat (150) @(posedge i_clk);
        chk("rst_no_done", 32'(done_cnt - d0), 0);

        d0 = done_cnt;
        pulse_start(21'h03000, 1'b1);
        wait_done(d0 + 1);
        chk("post_rst_span", 32'(span), 96);
        cpu_access(1'b0, 21'h01234, 8'h00, 3);

        repeat (10) @(posedge i_clk);
        chk("cpu_q_empty", 32'(cpu_q.size()), 0);
        chk("vid_q_empty", 32'(vid_q.size()), 0);
        chk("ovr_left", 32'(exp_ovr), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
